// File: rtl/sequencer_lut_loader.sv
// rtl/sequencer_lut_loader.sv - assembles host words into 64-bit LUT entries, writes them
// and optionally verifies them by checksum readback before releasing the sequencer.
module sequencer_lut_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int WORD_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk_20mhz,
    input  logic              rst_n_20mhz,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   entry_count_i,
    input  logic              verify_en_i,
    input  logic              seq_busy_i,
    input  logic              word_valid_i,
    input  logic [WORD_W-1:0] word_data_i,
    output logic              word_ready_o,
    output logic [ADDR_W-1:0] lut_addr_o,
    output logic              lut_wen_o,
    output logic [DATA_W-1:0] lut_write_data_o,
    input  logic [DATA_W-1:0] lut_read_data_i,
    output logic              load_busy_o,
    output logic              config_done_o,
    output logic              error_o,
    output logic [31:0]       checksum_o,
    output logic [ADDR_W:0]   entries_written_o
);

    localparam int WORDS  = DATA_W / WORD_W;
    localparam int WIDX_W = $clog2(WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SEQ,
        ST_FILL,
        ST_WRITE,
        ST_VERIFY_RD,
        ST_VERIFY_CMP,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                verify_q, verify_d;
    logic [ADDR_W:0]     entry_idx_q, entry_idx_d;
    logic [ADDR_W:0]     rd_idx_q, rd_idx_d;
    logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wr_cksum_q, wr_cksum_d;
    logic [31:0]         rd_cksum_q, rd_cksum_d;
    logic [RD_LAT-1:0]   rd_valid_q, rd_valid_d;
    logic                rd_issue;
    logic [ADDR_W:0]     entry_next;
    logic [ADDR_W:0]     rd_next;

    function automatic logic [31:0] entry_sum(input logic [DATA_W-1:0] d);
        return d[DATA_W-1 -: 32] + d[31:0];
    endfunction

    assign entry_next = entry_idx_q + 1'b1;
    assign rd_next    = rd_idx_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        count_d      = count_q;
        verify_d     = verify_q;
        entry_idx_d  = entry_idx_q;
        rd_idx_d     = rd_idx_q;
        word_idx_d   = word_idx_q;
        asm_d        = asm_q;
        wr_cksum_d   = wr_cksum_q;
        rd_issue     = 1'b0;
        word_ready_o = 1'b0;
        lut_wen_o    = 1'b0;
        lut_addr_o   = addr_q;

        // Readback data is accumulated whenever the latency pipe says it has arrived.
        rd_cksum_d = rd_valid_q[RD_LAT-1] ? rd_cksum_q + entry_sum(lut_read_data_i)
                                          : rd_cksum_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    base_d      = base_addr_i;
                    count_d     = entry_count_i;
                    verify_d    = verify_en_i;
                    entry_idx_d = '0;
                    rd_idx_d    = '0;
                    word_idx_d  = '0;
                    wr_cksum_d  = '0;
                    rd_cksum_d  = '0;
                    state_d     = ST_WAIT_SEQ;
                end
            end
            ST_WAIT_SEQ: begin
                if (count_q == '0) begin
                    state_d = ST_DONE;
                end else if (!seq_busy_i) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                word_ready_o = 1'b1;
                if (word_valid_i) begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (word_idx_q == WIDX_W'(w)) begin
                            asm_d[w*WORD_W +: WORD_W] = word_data_i;
                        end
                    end
                    word_idx_d = word_idx_q + 1'b1;
                    if (word_idx_q == WIDX_W'(WORDS - 1)) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                lut_wen_o   = 1'b1;
                lut_addr_o  = base_q + entry_idx_q[ADDR_W-1:0];
                wr_cksum_d  = wr_cksum_q + entry_sum(asm_q);
                entry_idx_d = entry_next;
                if (entry_next == count_q) begin
                    state_d = verify_q ? ST_VERIFY_RD : ST_DONE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_VERIFY_RD: begin
                rd_issue   = 1'b1;
                lut_addr_o = base_q + rd_idx_q[ADDR_W-1:0];
                rd_idx_d   = rd_next;
                if (rd_next == count_q) begin
                    state_d = ST_VERIFY_CMP;
                end
            end
            ST_VERIFY_CMP: begin
                // Compare only once every in-flight return has landed in rd_cksum_q.
                if (rd_valid_q == '0) begin
                    state_d = (rd_cksum_q == wr_cksum_q) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_valid_d[0] = rd_issue;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_valid_d[i] = rd_valid_q[i-1];
        end
    end

    always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
        if (!rst_n_20mhz) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            verify_q    <= 1'b0;
            entry_idx_q <= '0;
            rd_idx_q    <= '0;
            word_idx_q  <= '0;
            asm_q       <= '0;
            addr_q      <= '0;
            wr_cksum_q  <= '0;
            rd_cksum_q  <= '0;
            rd_valid_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            verify_q    <= verify_d;
            entry_idx_q <= entry_idx_d;
            rd_idx_q    <= rd_idx_d;
            word_idx_q  <= word_idx_d;
            asm_q       <= asm_d;
            addr_q      <= lut_addr_o;
            wr_cksum_q  <= wr_cksum_d;
            rd_cksum_q  <= rd_cksum_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign lut_write_data_o  = asm_q;
    assign load_busy_o       = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
    assign config_done_o     = (state_q == ST_DONE);
    assign error_o           = (state_q == ST_ERROR);
    assign checksum_o        = wr_cksum_q;
    assign entries_written_o = entry_idx_q;

endmodule

// File: tb/tb_sequencer_lut_loader.sv
// tb/tb_sequencer_lut_loader.sv - scoreboard bench; two loaders (read latency 1 and 3) share
// the host stimulus, each backed by its own LUT model.
module tb_sequencer_lut_loader;

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic        done;
        logic        err;
        logic [31:0] cksum;
        logic [8:0]  cnt;
    } st_t;

    localparam logic [63:0] E0 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] E1 = 64'hDDDD_CCCC_BBBB_AAAA;
    localparam logic [31:0] CK = 32'hFFFF_BBBA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  entry_count;
    logic        verify_en;
    logic        seq_busy;
    logic        word_valid;
    logic [15:0] word_data;
    logic        corrupt;

    logic [1:0]        word_ready, wen, busy, done, err;
    logic [1:0][7:0]   addr;
    logic [1:0][63:0]  wdata, rdata;
    logic [1:0][31:0]  cksum;
    logic [1:0][8:0]   entries;

    logic        chk_reset, chk_ready_en, chk_ready_val, chk_done_en, chk_done_val, end_flag;
    logic [15:0] words [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                               16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

    wr_t wq[$];
    st_t stq0[$];
    st_t stq1[$];
    int  checks = 0;
    int  errors = 0;

    always #25 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [63:0] mem  [256];
        logic [63:0] pipe [LAT];

        sequencer_lut_loader #(.ADDR_W(8), .DATA_W(64), .WORD_W(16), .RD_LAT(LAT)) dut (
            .clk_20mhz         (clk),
            .rst_n_20mhz       (rst_n),
            .start_i           (start),
            .base_addr_i       (base_addr),
            .entry_count_i     (entry_count),
            .verify_en_i       (verify_en),
            .seq_busy_i        (seq_busy),
            .word_valid_i      (word_valid),
            .word_data_i       (word_data),
            .word_ready_o      (word_ready[g]),
            .lut_addr_o        (addr[g]),
            .lut_wen_o         (wen[g]),
            .lut_write_data_o  (wdata[g]),
            .lut_read_data_i   (rdata[g]),
            .load_busy_o       (busy[g]),
            .config_done_o     (done[g]),
            .error_o           (err[g]),
            .checksum_o        (cksum[g]),
            .entries_written_o (entries[g])
        );

        always @(posedge clk) begin
            if (wen[g]) mem[addr[g]] <= wdata[g];
            pipe[0] <= mem[addr[g]] ^ {63'd0, (corrupt && addr[g] == 8'h11)};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign rdata[g] = pipe[LAT-1];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stat_check(input int g, input st_t e);
        chk($sformatf("config_done%0d", g), 64'(done[g]), 64'(e.done));
        chk($sformatf("error%0d", g), 64'(err[g]), 64'(e.err));
        chk($sformatf("checksum%0d", g), 64'(cksum[g]), 64'(e.cksum));
        chk($sformatf("entries_written%0d", g), 64'(entries[g]), 64'(e.cnt));
    endtask

    logic [1:0]  prev_busy = 2'b00;
    int unsigned wait0 = 0;
    int unsigned wait1 = 0;

    always @(negedge clk) begin
        if (end_flag) begin
            chk("writes_left", 64'(wq.size()), 64'd0);
            chk("status0_left", 64'(stq0.size()), 64'd0);
            chk("status1_left", 64'(stq1.size()), 64'd0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
        if (!rst_n) begin
            prev_busy = 2'b00;
            if (chk_reset) begin
                for (int g = 0; g < 2; g++) begin
                    chk($sformatf("reset_ctrl%0d", g),
                        64'({word_ready[g], wen[g], busy[g], done[g], err[g], addr[g], entries[g]}), 64'd0);
                    chk($sformatf("reset_wdata%0d", g), wdata[g], 64'd0);
                    chk($sformatf("reset_cksum%0d", g), 64'(cksum[g]), 64'd0);
                end
            end
        end else begin
            if (wen != 2'b00) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 64'(wen), 64'd0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    for (int g = 0; g < 2; g++) begin
                        chk($sformatf("wen%0d", g), 64'(wen[g]), 64'd1);
                        chk($sformatf("waddr%0d", g), 64'(addr[g]), 64'(e.addr));
                        chk($sformatf("wdata%0d", g), wdata[g], e.data);
                    end
                end
            end
            if (chk_ready_en) begin
                chk("word_ready0", 64'(word_ready[0]), 64'(chk_ready_val));
                chk("word_ready1", 64'(word_ready[1]), 64'(chk_ready_val));
            end
            if (chk_done_en) begin
                chk("done_timing0", 64'(done[0]), 64'(chk_done_val));
                chk("done_timing1", 64'(done[1]), 64'(chk_done_val));
            end
            if (prev_busy[0] && !busy[0]) begin
                if (stq0.size() == 0) chk("unexpected_finish0", 64'({done[0], err[0]}), 64'd0);
                else stat_check(0, stq0.pop_front());
            end
            if (prev_busy[1] && !busy[1]) begin
                if (stq1.size() == 0) chk("unexpected_finish1", 64'({done[1], err[1]}), 64'd0);
                else stat_check(1, stq1.pop_front());
            end
            wait0 = (stq0.size() != 0) ? wait0 + 1 : 0;
            wait1 = (stq1.size() != 0) ? wait1 + 1 : 0;
            if (wait0 > 3000) begin
                checks++; errors++;
                $display("FAIL load_timeout0: waited %0d cycles, limit 3000", wait0);
                void'(stq0.pop_front()); wait0 = 0;
            end
            if (wait1 > 3000) begin
                checks++; errors++;
                $display("FAIL load_timeout1: waited %0d cycles, limit 3000", wait1);
                void'(stq1.pop_front()); wait1 = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_writes(input logic [7:0] b);
        logic [7:0] b1;
        b1 = b + 8'd1;
        wq.push_back('{addr: b, data: E0});
        wq.push_back('{addr: b1, data: E1});
    endtask

    task automatic push_status(input logic d, input logic e, input logic [31:0] c, input logic [8:0] n);
        stq0.push_back('{done: d, err: e, cksum: c, cnt: n});
        stq1.push_back('{done: d, err: e, cksum: c, cnt: n});
    endtask

    task automatic start_load(input logic [7:0] b, input logic [8:0] n, input logic v);
        base_addr   = b;
        entry_count = n;
        verify_en   = v;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        bit accepted = 1'b0;
        int n = 0;
        word_valid = 1'b1;
        word_data  = w;
        while (!accepted && n < 200) begin
            @(negedge clk);
            accepted = word_ready[0];
            tick();
            n++;
        end
        word_valid = 1'b0;
    endtask

    task automatic send_words(input int num);
        for (int i = 0; i < num; i++) send_word(words[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((stq0.size() != 0 || stq1.size() != 0) && n < 4000) begin
            tick();
            n++;
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; entry_count = '0; verify_en = 1'b0;
        seq_busy = 1'b0; word_valid = 1'b0; word_data = '0; corrupt = 1'b0;
        chk_reset = 1'b0; chk_ready_en = 1'b0; chk_ready_val = 1'b0;
        chk_done_en = 1'b0; chk_done_val = 1'b0; end_flag = 1'b0;
        repeat (2) tick();
        chk_reset = 1'b1;
        tick();
        chk_reset = 1'b0;
        rst_n = 1'b1;
        tick();

        // Two entries, no verify.
        push_writes(8'h10); push_status(1'b1, 1'b0, CK, 9'd2);
        start_load(8'h10, 9'd2, 1'b0); send_words(8); wait_idle();

        // Same with readback verify on both latencies.
        push_writes(8'h10); push_status(1'b1, 1'b0, CK, 9'd2);
        start_load(8'h10, 9'd2, 1'b1); send_words(8); wait_idle();

        // Corrupted readback of entry 0x11.
        corrupt = 1'b1;
        push_writes(8'h10); push_status(1'b0, 1'b1, CK, 9'd2);
        start_load(8'h10, 9'd2, 1'b1); send_words(8); wait_idle();
        corrupt = 1'b0;

        // Address wrap from 0xFF to 0x00.
        push_writes(8'hFF); push_status(1'b1, 1'b0, CK, 9'd2);
        start_load(8'hFF, 9'd2, 1'b1); send_words(8); wait_idle();

        // Sequencer busy holds the load off for 10 cycles.
        seq_busy = 1'b1;
        push_writes(8'h10); push_status(1'b1, 1'b0, CK, 9'd2);
        start_load(8'h10, 9'd2, 1'b0);
        chk_ready_val = 1'b0; chk_ready_en = 1'b1;
        repeat (10) tick();
        seq_busy = 1'b0;
        tick();
        chk_ready_val = 1'b1;
        tick();
        chk_ready_en = 1'b0;
        send_words(8); wait_idle();

        // Zero entries: done two cycles after start, no writes.
        push_status(1'b1, 1'b0, 32'd0, 9'd0);
        start_load(8'h20, 9'd0, 1'b1);
        chk_done_val = 1'b0; chk_done_en = 1'b1;
        tick();
        chk_done_val = 1'b1;
        tick();
        chk_done_en = 1'b0;
        wait_idle();

        // Reset after two words of an entry, then a clean reload.
        start_load(8'h10, 9'd2, 1'b0);
        send_words(2);
        rst_n = 1'b0;
        chk_reset = 1'b1;
        tick();
        chk_reset = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        push_writes(8'h30); push_status(1'b1, 1'b0, CK, 9'd2);
        start_load(8'h30, 9'd2, 1'b1); send_words(8); wait_idle();

        end_flag = 1'b1;
        repeat (5) tick();
        $display("FAIL monitor_end: summary not reached");
        $fatal(1);
    end

endmodule
